// File: rtl/cache_switch_controller.sv
// Purpose : switches CPU data traffic between NUM_CACHES write-back dcaches, draining the active one first.
// Latency : strobe to new active_cache is 2 edges when the active cache is idle; 1 extra edge per drain cycle.
// Backpress: busywait follows the active cache, and is forced high for the single SWITCH cycle.
//
// Ports: clock/reset (sync, active-high); CPU side read/write/address/writedata -> readdata/busywait;
// select side func3_cache_select_reg_value + write_cache_select_reg; memory side mem_* (one
// shared port driven by the active cache); status active_cache and saturating switch_count.

module dcache (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);
    // Direct-mapped, 8 lines of 4 words, write-back / write-allocate.
    typedef enum logic [1:0] {C_IDLE, C_WBACK, C_FETCH} cstate_t;

    cstate_t      state, state_nxt;
    logic [127:0] data_arr [8];
    logic [24:0]  tag_arr  [8];
    logic [7:0]   valid, dirty;
    logic [2:0]   idx;
    logic [1:0]   off;
    logic [24:0]  tag;
    logic         hit;
    logic         fill;
    logic         unused_addr;

    assign idx         = address[6:4];
    assign off         = address[3:2];
    assign tag         = address[31:7];
    assign hit         = valid[idx] && (tag_arr[idx] == tag);
    assign fill        = (state == C_FETCH) && !mem_busywait;
    assign readdata    = data_arr[idx][{off, 5'b0} +: 32];
    assign unused_addr = &{1'b0, address[1:0]};

    always_comb begin
        state_nxt     = state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = address[31:4];
        mem_writedata = data_arr[idx];
        case (state)
            C_IDLE: begin
                if ((read || write) && !hit) begin
                    busywait  = 1'b1;
                    state_nxt = dirty[idx] ? C_WBACK : C_FETCH;
                end
            end
            C_WBACK: begin
                busywait    = 1'b1;
                mem_write   = 1'b1;
                mem_address = {tag_arr[idx], idx};
                if (!mem_busywait) state_nxt = C_FETCH;
            end
            C_FETCH: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) state_nxt = C_IDLE;
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= C_IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_nxt;
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (state == C_IDLE && write && hit) begin
                dirty[idx] <= 1'b1;
            end
        end
    end

    // Line storage carries no reset; valid bits guard it.
    always_ff @(posedge clock) begin
        if (fill) begin
            data_arr[idx] <= mem_readdata;
            tag_arr[idx]  <= tag;
        end else if (state == C_IDLE && write && hit) begin
            data_arr[idx][{off, 5'b0} +: 32] <= writedata;
        end
    end
endmodule

module cache_switch_controller #(
    parameter int NUM_CACHES = 4,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          read,
    input  logic                          write,
    input  logic [31:0]                   address,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          busywait,
    input  logic [SEL_W-1:0]              func3_cache_select_reg_value,
    input  logic                          write_cache_select_reg,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [27:0]                   mem_address,
    output logic [127:0]                  mem_writedata,
    input  logic [127:0]                  mem_readdata,
    input  logic                          mem_busywait,
    output logic [$clog2(NUM_CACHES)-1:0] active_cache,
    output logic [CNT_W-1:0]              switch_count
);
    localparam int IDX_W = $clog2(NUM_CACHES);

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     pending, pending_nxt, req_idx;
    logic                 active_bw;
    logic                 cpu_gate;
    logic [NUM_CACHES-1:0] cache_read, cache_write, cache_mem_bw, cache_bw;
    logic [NUM_CACHES-1:0] cache_mem_read, cache_mem_write;
    logic [31:0]          cache_rdata  [NUM_CACHES];
    logic [27:0]          cache_maddr  [NUM_CACHES];
    logic [127:0]         cache_mwdata [NUM_CACHES];

    // Values 1..N-1 pick cache v-1; 0 and anything out of range pick the last cache.
    always_comb begin
        req_idx = IDX_W'(NUM_CACHES - 1);
        if (func3_cache_select_reg_value != '0 &&
            func3_cache_select_reg_value <= SEL_W'(NUM_CACHES - 1))
            req_idx = IDX_W'(func3_cache_select_reg_value - SEL_W'(1));
    end

    assign cpu_gate  = (state != SWITCH);
    assign active_bw = cache_bw[active_cache];

    for (genvar i = 0; i < NUM_CACHES; i++) begin : g_cache
        assign cache_read[i]   = read  && cpu_gate && (active_cache == IDX_W'(i));
        assign cache_write[i]  = write && cpu_gate && (active_cache == IDX_W'(i));
        assign cache_mem_bw[i] = mem_busywait && (active_cache == IDX_W'(i));

        dcache u_dcache (
            .clock         (clock),
            .reset         (reset),
            .read          (cache_read[i]),
            .write         (cache_write[i]),
            .address       (address),
            .writedata     (writedata),
            .readdata      (cache_rdata[i]),
            .busywait      (cache_bw[i]),
            .mem_read      (cache_mem_read[i]),
            .mem_write     (cache_mem_write[i]),
            .mem_address   (cache_maddr[i]),
            .mem_writedata (cache_mwdata[i]),
            .mem_readdata  (mem_readdata),
            .mem_busywait  (cache_mem_bw[i])
        );
    end

    assign readdata      = cache_rdata[active_cache];
    assign mem_read      = cache_mem_read[active_cache];
    assign mem_write     = cache_mem_write[active_cache];
    assign mem_address   = cache_maddr[active_cache];
    assign mem_writedata = cache_mwdata[active_cache];
    assign busywait      = (state == SWITCH) ? 1'b1 : active_bw;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (write_cache_select_reg && req_idx != active_cache) begin
                    pending_nxt = req_idx;
                    state_nxt   = active_bw ? DRAIN : SWITCH;
                end
            end
            DRAIN: begin
                // Last strobe wins; re-selecting the active cache cancels the switch.
                if (write_cache_select_reg) begin
                    pending_nxt = req_idx;
                    if (req_idx == active_cache) state_nxt = IDLE;
                    else if (!active_bw)         state_nxt = SWITCH;
                end else if (!active_bw) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= IDX_W'(NUM_CACHES - 1);
            active_cache <= IDX_W'(NUM_CACHES - 1);
            switch_count <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (state == SWITCH) begin
                active_cache <= pending;
                if (switch_count != '1) switch_count <= switch_count + 1'b1;
            end
        end
    end
endmodule
